pipe_elastic_buf: RTL and testbench
===================================

Name: pipe_elastic_buf

Overview:
- Parametrised inter-stage buffer for the in-order pipeline.
- Generalises the single-entry stage latch (valid reg plus allowin = !valid || downstream ready) to a DEPTH-entry elastic queue carrying a WIDTH-bit stage bus.
- Adds a flush input for branch or exception cancel, and an occupancy output.
- Sits between any two stages, e.g. IF->ID bus or ID->EX bus. DEPTH=1 reproduces the classic stage latch exactly.

Parameters:
- WIDTH, 64, stage bus width in bits (>=1).
- DEPTH, 2, number of storage entries (>=1, any integer; need not be a power of two).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  Single clock, rising edge.
- reset  in  1  Asynchronous, active-high. Clears all state immediately.
- flush  in  1  Cancel all held and incoming entries this cycle.
- in_valid  in  1  Upstream stage has a valid bus.
- in_ready  out  1  Allowin to upstream.
- in_bus  in  WIDTH  Upstream stage bus.
- out_valid  out  1  Head entry valid to downstream.
- out_ready  in  1  Downstream allowin.
- out_bus  out  WIDTH  Head entry bus.
- count  out  CNT_W  Current number of stored entries.

Behaviour:
- Storage: circular array mem[DEPTH] of WIDTH bits.
  - Registers rd_ptr and wr_ptr wrap from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
  - count register holds 0..DEPTH.
- Asynchronous reset: rd_ptr=0, wr_ptr=0, count=0.
  - Outputs during and after reset: out_valid=0, out_bus=0, in_ready=1, count=0.
  - mem contents are not reset.
  - Reset asserted mid-transfer drops every entry; no partial state survives.
- in_ready = (count < DEPTH) || out_ready. This is combinational, so a full buffer still accepts when the head pops in the same cycle.
- out_valid = (count != 0) && !flush.
- out_bus = mem[rd_ptr] when out_valid, else all-zero.
- push = in_valid && in_ready && !flush.
- pop = out_valid && out_ready.
- Clock edge update:
  - push only: write mem[wr_ptr], advance wr_ptr, count+1.
  - pop only: advance rd_ptr, count-1.
  - push and pop: write and both pointers advance; count unchanged. This includes the full case and the DEPTH=1 case.
  - flush: rd_ptr=wr_ptr=0, count=0. Flush has priority over push and pop. No entry is delivered downstream in the flush cycle.
- Latency: minimum 1 cycle from in_valid accepted to out_valid.
- Throughput: 1 entry per cycle sustained whenever out_ready=1.
- Boundary conditions:
  - Empty with out_ready=1: out_valid=0, and the pop term is inert.
  - Full with out_ready=0: in_ready=0; upstream must hold in_valid and in_bus stable.
  - The buffer never overwrites a stored entry and never underflows. Flag an assertion if count would exceed DEPTH or drop below 0.
- No combinational path from in_valid or in_bus to out_valid or out_bus, except under the optional feature below.

Optional Feature:
- Macro: PIPE_ELASTIC_BUF_BYPASS_EN
- Defined: when count==0 && in_valid && out_ready && !flush:
  - out_valid=1 and out_bus=in_bus combinationally, giving zero-cycle latency.
  - The entry is consumed directly; no write occurs and count stays 0.
  - With count!=0, behaviour is unchanged.
- Undefined: strict registered behaviour as described under Behaviour; minimum latency 1 cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - Bus-width constants IF_ID_BUS_W=64, ID_EX_BUS_W=151, EX_ME_BUS_W=73, ME_WB_BUS_W=69, BR_BUS_W=32.
  - A clog2-based count-width helper.
- One natural sub-module: pipe_buf_ptr. It is a wrapping pointer counter with async reset, an inc input, a clear input and a DEPTH parameter, instantiated twice (rd and wr).
- Storage array and control stay in the top.

Test Plan:
- All cases use WIDTH=32, DEPTH=4.
- Reset then idle: assert reset mid-run with count=3 -> count=0, out_valid=0, in_ready=1 immediately. out_bus=0 after release.
- Fill: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count 1..4, in_ready=0 after 4th push. A 5th in_valid is not accepted. Then out_ready=1 pops 0x11,0x22,0x33,0x44 in order on 4 consecutive cycles.
- Full simultaneous push/pop: count=4, in_valid=1 with 0x55, out_ready=1 -> in_ready=1, 0x11 popped, count stays 4. Tail becomes 0x55 after wrap (wr_ptr 0).
- Streaming: continuous in_valid with incrementing data from 0x100, out_ready=1 for 20 cycles -> one output per cycle, 1-cycle lag, count steady at 1, pointers wrap 5 times without loss.
- Flush: count=3, flush=1 with in_valid=1 and out_ready=1 -> out_valid=0 that cycle, no pop, no push. Next cycle count=0, a fresh push of 0xAA appears first.
- DEPTH=1 regression, plus bypass build: DEPTH=1 with alternating out_ready behaves as the classic latch (allowin = !valid || out_ready). With PIPE_ELASTIC_BUF_BYPASS_EN, empty buffer, in 0x77 with out_ready=1 -> out_bus=0x77 in the same cycle, count stays 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: stage bus widths and width helpers for buffer counters/pointers.
package pipe_pkg;

    localparam int IF_ID_BUS_W = 64;
    localparam int ID_EX_BUS_W = 151;
    localparam int EX_ME_BUS_W = 73;
    localparam int ME_WB_BUS_W = 69;
    localparam int BR_BUS_W    = 32;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width needed to index depth entries; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// Wrapping pointer counter for a DEPTH-entry circular buffer; wraps DEPTH-1 -> 0 by compare.
module pipe_buf_ptr
    import pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (clear) begin
            ptr_next = '0;
        end else if (inc) begin
            ptr_next = (ptr_reg == LAST) ? '0 : ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/pipe_elastic_buf.sv
// DEPTH-entry elastic inter-stage buffer with flush and occupancy output.
// Optional zero-latency pass-through when empty: define PIPE_ELASTIC_BUF_BYPASS_EN.
module pipe_elastic_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bus,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             stored_valid;
    logic             bypass;
    logic             push;
    logic             pop;

    assign stored_valid = (count_reg != '0) && !flush;

`ifdef PIPE_ELASTIC_BUF_BYPASS_EN
    assign bypass = (count_reg == '0) && in_valid && out_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A full buffer still accepts when the head leaves in the same cycle.
    assign in_ready  = (count_reg < FULL_CNT) || out_ready;
    assign out_valid = stored_valid || bypass;
    assign out_bus   = bypass       ? in_bus      :
                       stored_valid ? mem[rd_ptr] : '0;

    // A bypassed entry goes straight downstream and never touches storage.
    assign push = in_valid && in_ready && !flush && !bypass;
    assign pop  = stored_valid && out_ready;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_bus;
        end
    end

    pipe_buf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push),
        .clear (flush),
        .ptr   (wr_ptr)
    );

    pipe_buf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop),
        .clear (flush),
        .ptr   (rd_ptr)
    );

    assign count = count_reg;

    overflow_chk: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_reg == FULL_CNT)));
    underflow_chk: assert property (@(posedge clk) disable iff (reset)
        !(pop && !push && (count_reg == '0)));

endmodule

// File: tb/tb_pipe_elastic_buf.sv
// Randomised scoreboard bench for pipe_elastic_buf (DEPTH=4 main instance, DEPTH=1 latch instance).
module tb_pipe_elastic_buf;

    localparam int W  = 32;
    localparam int D  = 4;

`ifdef PIPE_ELASTIC_BUF_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          flush, in_valid, out_ready, in_ready, out_valid;
    logic [W-1:0]  in_bus, out_bus;
    logic [2:0]    count;

    logic          d1_flush, d1_in_valid, d1_out_ready, d1_in_ready, d1_out_valid;
    logic [W-1:0]  d1_in_bus, d1_out_bus;
    logic [0:0]    d1_count;

    int checks = 0;
    int passed = 0;

    logic [W-1:0] model_q[$];
    logic [W-1:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_elastic_buf #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus),
        .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus),
        .count(count)
    );

    pipe_elastic_buf #(.WIDTH(W), .DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .flush(d1_flush),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_bus(d1_in_bus),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_bus(d1_out_bus),
        .count(d1_count)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every downstream handshake must deliver the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", out_bus, 32'hDEAD_BEEF);
            end else begin
                logic [W-1:0] exp_v;
                exp_v = sb_q.pop_front();
                check("out_bus_order", out_bus, exp_v);
                $display("pop  data=0x%0h count=%0d", out_bus, count);
            end
        end
    end

    // One cycle: drive at posedge+1, check mid-cycle, commit the model at the next posedge.
    task automatic step(input logic iv, input logic [W-1:0] ib, input logic ordy, input logic fl);
        logic byp, exp_valid, exp_ready;
        int   sz;
        sz        = model_q.size();
        in_valid  = iv;
        in_bus    = ib;
        out_ready = ordy;
        flush     = fl;
        byp       = BYPASS_EN && (sz == 0) && iv && ordy && !fl;
        if (byp) sb_q.push_back(ib);
        exp_valid = ((sz != 0) && !fl) || byp;
        exp_ready = (sz < D) || ordy;
        @(negedge clk);
        check("count", W'(count), W'(sz));
        check("in_ready", W'(in_ready), W'(exp_ready));
        check("out_valid", W'(out_valid), W'(exp_valid));
        if (!exp_valid) check("out_bus_idle", out_bus, '0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
            sb_q.delete();
        end else begin
            if (exp_valid && ordy && !byp) void'(model_q.pop_front());
            if (iv && exp_ready && !byp) begin
                model_q.push_back(ib);
                sb_q.push_back(ib);
            end
        end
        $display("step iv=%0d in=0x%0h ordy=%0d flush=%0d -> occupancy %0d", iv, ib, ordy, fl, model_q.size());
        #1;
    endtask

    initial begin
        logic v;
        logic [W-1:0] dat;
        reset = 1'b1;
        flush = 0; in_valid = 0; out_ready = 0; in_bus = '0;
        d1_flush = 0; d1_in_valid = 0; d1_out_ready = 0; d1_in_bus = '0;
        #12;
        check("rst_count", W'(count), '0);
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_in_ready", W'(in_ready), 32'd1);
        check("rst_out_bus", out_bus, '0);
        @(posedge clk); #1 reset = 1'b0;

        // Fill, refuse a fifth entry, then simultaneous push/pop while full.
        step(1, 32'h11, 0, 0); step(1, 32'h22, 0, 0);
        step(1, 32'h33, 0, 0); step(1, 32'h44, 0, 0);
        step(1, 32'h99, 0, 0);
        step(1, 32'h55, 1, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);

        // Streaming at full rate.
        for (int i = 0; i < 20; i++) step(1, 32'h100 + W'(i), 1, 0);
        step(0, '0, 1, 0);

        // Flush with traffic on both sides, then a fresh entry.
        step(1, 32'h1, 0, 0); step(1, 32'h2, 0, 0); step(1, 32'h3, 0, 0);
        step(1, 32'hBB, 1, 1);
        step(1, 32'hAA, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0));
        for (int i = 0; i < 6; i++) step(0, '0, 1, 0);
        check("sb_drained", W'(sb_q.size()), '0);

        // Asynchronous reset mid-run with three entries held.
        step(1, 32'h61, 0, 0); step(1, 32'h62, 0, 0); step(1, 32'h63, 0, 0);
        in_valid = 0;
        #2 reset = 1'b1;
        #1;
        check("amid_count", W'(count), '0);
        check("amid_out_valid", W'(out_valid), '0);
        check("amid_in_ready", W'(in_ready), 32'd1);
        model_q.delete(); sb_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        step(0, '0, 1, 0);
        step(1, 32'h70, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // DEPTH=1 instance against the classic stage latch.
        v = 1'b0; dat = '0;
        for (int i = 0; i < 16; i++) begin
            logic ordy, byp, allow, acc;
            ordy = ((i % 3) != 0);
            d1_in_valid  = 1'b1;
            d1_in_bus    = 32'h200 + W'(i);
            d1_out_ready = ordy;
            byp   = BYPASS_EN && !v && ordy;
            allow = !v || ordy;
            @(negedge clk);
            check("d1_in_ready", W'(d1_in_ready), W'(allow));
            check("d1_out_valid", W'(d1_out_valid), W'(v || byp));
            check("d1_out_bus", d1_out_bus, v ? dat : (byp ? d1_in_bus : '0));
            @(posedge clk);
            acc = allow && !byp;
            if (acc) dat = d1_in_bus;
            v = acc ? 1'b1 : (v && !ordy);
            $display("d1 in=0x%0h ordy=%0d -> valid %0d", d1_in_bus, ordy, v);
            #1;
        end
        d1_in_valid = 0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
